tone_detector: RTL and testbench
================================

// Module: tone_detector
// PURPOSE
//   Receive-side counterpart of the square-wave tone generator. Measures the period of an
//   incoming square wave (e.g. speaker loopback or a player's tone input) in clk ticks, then
//   converts it to a 10-bit frequency in Hz with a sequential divider. The result uses the
//   same units as the generator's freq input, so detected tones compare directly to game tones.
// PARAMETERS
//   PERIOD_W    16   width of the period counter (ticks between rising edges)
//   TIMEOUT_MS  100  ms with no rising edge before the input is declared silent
// PORTS
//   clk              input   1   system clock
//   rst_n            input   1   asynchronous reset, active low
//   ticks_per_milli  input   6   clk ticks per millisecond; 0 = detector disabled
//   sound_in         input   1   asynchronous square-wave input
//   freq             output  10  last measured frequency in Hz; 0 = silent
//   freq_valid       output  1   1-cycle pulse when freq is updated by a measurement
//   silent           output  1   1 = no valid tone (reset, timeout or disabled)
// BEHAVIOUR
//   - Reset (async, rst_n=0): freq=0, freq_valid=0, silent=1, sync flops=0, counter=0,
//     unarmed, FSM=IDLE. Asserting reset mid-division aborts it; nothing is output.
//   - Input: sound_in -> s1 -> s2 (2-FF sync); s3 <= s2. rise = s2 & ~s3.
//     A cycle with rise=1 is an edge cycle E. Falling edges are ignored.
//   - Period counter cnt (PERIOD_W bits): cleared to 0 on an edge cycle, else +1, saturating
//     at all-ones. At an edge, the measured period is P = cnt+1, so a wave with period T clks gives P=T.
//   - Armed flag: the first edge after reset, timeout or disable only sets armed=1.
//     No division is started for that edge.
//   - tps = ticks_per_milli*1000 (16 bits; max 63000). tmo = ticks_per_milli*TIMEOUT_MS
//     (compute at PERIOD_W+7 bits).
//   - FSM IDLE -> DIV -> DONE -> IDLE:
//     IDLE: on an edge with armed=1, load dividend=tps and divisor=P, then go to DIV.
//     DIV: restoring divide, 1 quotient bit/cycle, exactly 16 cycles (E+1..E+16).
//     DONE (cycle E+17): freq <= min(quotient,1023); freq_valid=1 for that cycle only;
//     silent <= 0; then go to IDLE.
//   - Edge while in DIV/DONE: cnt still clears and armed stays 1, but no new division starts
//     (that measurement is dropped). The division in flight completes normally.
//   - Timeout: if cnt+1 >= tmo with no edge, then freq <= 0, silent <= 1, armed <= 0, no
//     freq_valid. An in-flight division is aborted and the FSM returns to IDLE.
//     Saturation of cnt with tmo beyond range is treated as a timeout.
//   - ticks_per_milli==0: each cycle force freq=0, silent=1, armed=0, cnt=0, FSM=IDLE.
//   - Quotient 0 (P > tps): freq=0 with freq_valid=1 and silent=0. freq between valid
//     pulses holds its last value.
//   - Division is always of the period captured at start. Changes to ticks_per_milli
//     during DIV take effect on the next measurement.
// TESTING
//   1. tpm=50, sound_in period 100 clk, 50% duty -> first edge: no pulse; 2nd edge E: freq=500,
//      freq_valid at E+17, silent 1->0; repeats every edge.
//   2. tpm=50, period 40 -> freq=1250 clamps to 1023; period 60000 (>tmo? set TIMEOUT_MS
//      large) -> freq=0 with valid pulse.
//   3. tpm=10, TIMEOUT_MS=100, tone then hold sound_in low -> 1000 clk after last edge:
//      freq=0, silent=1; one later edge gives no freq_valid; the 2nd edge measures.
//   4. tpm=1, period 10 -> 1000/10=100; edges inside DIV dropped, freq_valid only on edges
//      found in IDLE, freq=100 always.
//   5. Pull rst_n low at E+8 of a division -> immediately freq=0, silent=1, freq_valid
//      never pulses; after release the first edge only arms.
//   6. Tone running, tpm set to 0 -> next cycle freq=0, silent=1; restore tpm=50 -> two edges
//      needed before freq_valid.

Source files
------------

// File: rtl/tone_detector.sv
// Measures the period of an asynchronous square wave in clk ticks and converts it to a
// 10-bit frequency in Hz with a 16-cycle restoring divider.
module tone_detector #(
    parameter int PERIOD_W   = 16,
    parameter int TIMEOUT_MS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] ticks_per_milli,
    input  logic       sound_in,
    output logic [9:0] freq,
    output logic       freq_valid,
    output logic       silent
);

    localparam int TMO_W = PERIOD_W + 7;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state, state_next;

    logic                s1, s2, s3;
    logic                rise;
    logic [PERIOD_W-1:0] cnt;
    logic                cnt_sat;
    logic                armed;
    logic                enabled;
    logic                timeout;
    logic                start;
    logic                last_bit;

    logic [15:0]         tps;
    logic [TMO_W-1:0]    tmo;
    logic [TMO_W-1:0]    cnt_inc;
    logic [PERIOD_W:0]   period;

    // Divider datapath: dq shifts the dividend out at the top and the quotient in at the bottom.
    logic [15:0]         dq;
    logic [PERIOD_W:0]   rem;
    logic [PERIOD_W:0]   divisor;
    logic [3:0]          bit_cnt;
    logic [PERIOD_W+1:0] trial;
    logic [PERIOD_W+1:0] diff;
    logic                ge;
    logic [PERIOD_W:0]   rem_next;
    logic [15:0]         q_next;
    logic [9:0]          freq_calc;

    assign rise     = s2 & ~s3;
    assign enabled  = |ticks_per_milli;
    assign tps      = 16'(ticks_per_milli) * 16'd1000;
    assign tmo      = TMO_W'(ticks_per_milli) * TMO_W'(TIMEOUT_MS);
    assign cnt_inc  = TMO_W'(cnt) + TMO_W'(1);
    assign cnt_sat  = &cnt;
    assign period   = {1'b0, cnt} + {{PERIOD_W{1'b0}}, 1'b1};
    assign last_bit = (state == DIV) && (bit_cnt == 4'd15);

    // A saturated counter means tmo lies beyond what cnt can reach; treat it as silence too.
    assign timeout  = enabled && !rise && ((cnt_inc >= tmo) || cnt_sat);
    assign start    = enabled && rise && armed && (state == IDLE);

    always_comb begin
        trial     = {rem, dq[15]};
        diff      = trial - {1'b0, divisor};
        ge        = (trial >= {1'b0, divisor});
        rem_next  = ge ? diff[PERIOD_W:0] : trial[PERIOD_W:0];
        q_next    = {dq[14:0], ge};
        freq_calc = (q_next > 16'd1023) ? 10'd1023 : q_next[9:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (!enabled || timeout) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise && armed) state_next = DIV;
                DIV:     if (bit_cnt == 4'd15) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        freq_valid = (state == DONE) && enabled && !timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            cnt    <= '0;
            armed  <= 1'b0;
            freq   <= '0;
            silent <= 1'b1;
        end else begin
            s1 <= sound_in;
            s2 <= s1;
            s3 <= s2;
            if (!enabled) begin
                cnt    <= '0;
                armed  <= 1'b0;
                freq   <= '0;
                silent <= 1'b1;
            end else begin
                if (rise) begin
                    cnt <= '0;
                end else if (!cnt_sat) begin
                    cnt <= cnt + 1'b1;
                end
                if (timeout) begin
                    armed  <= 1'b0;
                    freq   <= '0;
                    silent <= 1'b1;
                end else begin
                    if (rise) armed <= 1'b1;
                    // Result registered as DIV ends so freq is already current while freq_valid is high.
                    if (last_bit) begin
                        freq   <= freq_calc;
                        silent <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq      <= '0;
            rem     <= '0;
            divisor <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            dq      <= tps;
            rem     <= '0;
            divisor <= period;
            bit_cnt <= '0;
        end else if (state == DIV) begin
            dq      <= q_next;
            rem     <= rem_next;
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: square-wave generator, freq_valid monitor and
// hand-computed expectations for period, clamp, zero quotient, drops, timeout, reset, disable.
module tb_tone_detector;

    localparam int TMO_MS = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] tpm = 6'd0;
    logic       sound_in = 1'b0;
    logic [9:0] freq;
    logic       freq_valid;
    logic       silent;

    tone_detector #(.PERIOD_W(16), .TIMEOUT_MS(TMO_MS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (tpm),
        .sound_in        (sound_in),
        .freq            (freq),
        .freq_valid      (freq_valid),
        .silent          (silent)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit run = 1'b0;
    int per = 100;
    int ph = 0;
    int rise_cyc = 0;

    int         vcount = 0;
    logic [9:0] last_f = '0;
    int         last_lat = -1;
    int         base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave source, driven on the falling edge; records the cycle of each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!run || per == 0) begin
                sound_in = 1'b0;
                ph = 0;
            end else begin
                if (ph == 0) begin
                    sound_in = 1'b1;
                    rise_cyc = cyc;
                end else if (ph == per / 2) begin
                    sound_in = 1'b0;
                end
                ph = (ph == per - 1) ? 0 : ph + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (freq_valid) begin
            vcount   = vcount + 1;
            last_f   = freq;
            last_lat = cyc - rise_cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic restart(input int t, input int p);
        run = 1'b0;
        tpm = 6'd0;
        repeat (5) @(negedge clk);
        tpm = 6'(t);
        per = p;
        run = 1'b1;
        base = vcount;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_freq", freq, 0);
        check("reset_valid", freq_valid, 0);
        check("reset_silent", silent, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 50 ticks/ms, period 100 -> 500 Hz, pulse 19 cycles after the driven rise
        tpm = 6'd50;
        per = 100;
        run = 1'b1;
        base = vcount;
        repeat (60) @(negedge clk);
        check("t1_first_edge_arms", vcount - base, 0);
        check("t1_silent_before", silent, 1);
        repeat (990) @(negedge clk);
        check("t1_pulses", vcount - base, 10);
        check("t1_freq", last_f, 500);
        check("t1_latency", last_lat, 19);
        check("t1_silent_after", silent, 0);

        // Disable mid-tone, then re-enable halfway between rises: two edges needed
        tpm = 6'd0;
        @(negedge clk);
        check("t6_disable_freq", freq, 0);
        check("t6_disable_silent", silent, 1);
        base = vcount;
        repeat (150) @(negedge clk);
        check("t6_disabled_no_pulse", vcount - base, 0);
        wait_cyc(rise_cyc + 50);
        tpm = 6'd50;
        base = vcount;
        repeat (110) @(negedge clk);
        check("t6_one_edge_no_pulse", vcount - base, 0);
        repeat (120) @(negedge clk);
        check("t6_second_edge_pulse", vcount - base, 1);
        check("t6_freq", last_f, 500);

        // Period 40 -> 1250 Hz clamps to 1023
        restart(50, 40);
        repeat (400) @(negedge clk);
        check("t2_clamp_pulses", vcount - base, 9);
        check("t2_clamp_freq", last_f, 1023);
        check("t2_clamp_silent", silent, 0);

        // 1 tick/ms, period 1500 > 1000 -> quotient 0, still valid
        restart(1, 1500);
        repeat (3100) @(negedge clk);
        check("t2_zero_pulses", vcount - base, 2);
        check("t2_zero_freq", last_f, 0);
        check("t2_zero_freq_hold", freq, 0);
        check("t2_zero_silent", silent, 0);

        // Period 10 -> 100 Hz; every other edge lands in DIV and is dropped
        restart(1, 10);
        repeat (400) @(negedge clk);
        check("t4_pulses", vcount - base, 19);
        check("t4_freq", last_f, 100);

        // Timeout after 2000 idle ticks (1 tick/ms)
        restart(1, 100);
        repeat (550) @(negedge clk);
        run = 1'b0;
        check("t3_pulses", vcount - base, 5);
        check("t3_freq", last_f, 10);
        base = vcount;
        wait_cyc(rise_cyc + 2002);
        check("t3_pre_timeout_silent", silent, 0);
        check("t3_pre_timeout_freq", freq, 10);
        wait_cyc(rise_cyc + 2003);
        check("t3_timeout_silent", silent, 1);
        check("t3_timeout_freq", freq, 0);
        check("t3_timeout_no_pulse", vcount - base, 0);
        run = 1'b1;
        base = vcount;
        repeat (60) @(negedge clk);
        check("t3_rearm_no_pulse", vcount - base, 0);
        repeat (100) @(negedge clk);
        check("t3_rearm_pulse", vcount - base, 1);
        check("t3_rearm_freq", last_f, 10);

        // Reset at E+8 of a division
        restart(50, 100);
        repeat (250) @(negedge clk);
        wait_cyc(rise_cyc + 110);
        base = vcount;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("t5_reset_freq", freq, 0);
        check("t5_reset_silent", silent, 1);
        check("t5_reset_valid", freq_valid, 0);
        repeat (30) @(negedge clk);
        check("t5_aborted_no_pulse", vcount - base, 0);
        rst_n = 1'b1;
        run = 1'b1;
        base = vcount;
        repeat (60) @(negedge clk);
        check("t5_first_edge_arms", vcount - base, 0);
        repeat (100) @(negedge clk);
        check("t5_second_edge_pulse", vcount - base, 1);
        check("t5_freq", last_f, 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
